// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the writeback (CDB) arbiter slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cdb_arbiter_pkg;

    // Default geometry of the result path
    localparam int CDB_N_SRC_DEF    = 3;
    localparam int CDB_DEPTH_DEF    = 4;
    localparam int CDB_ROB_ADDR_DEF = 4;   // matches the ROB id width
    localparam int CDB_DATA_W_DEF   = 32;

    // Source index assignment on the broadcast bus
    localparam int CDB_ALU = 0;
    localparam int CDB_LSB = 1;
    localparam int CDB_BRU = 2;

    // Round-robin candidate: the source 'step' positions after 'base'
    function automatic int rr_next(input int base, input int step, input int n);
        return (base + step) % n;
    endfunction

endpackage

// File: rtl/cdb_arbiter_src_fifo.sv
// Per-source result queue: DEPTH x W regfile with wr/rd pointers and occupancy count.
// Latency: a push at edge t is visible at head_dat/count after edge t.
// Backpressure: caller must not push when count == DEPTH or pop when count == 0; flush empties it.
// Ports: clk_in/rst_in clock and async active-low reset; flush/push/pop controls;
//        wr_dat entry written on push; head_dat oldest entry; count current occupancy.
module cdb_src_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 36,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     wr_dat,
    output logic [W-1:0]     head_dat,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage carries no reset; only pointers/count define validity.
    always_ff @(posedge clk_in) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/cdb_arbiter.sv
// Writeback scheduler: queues results per source, grants one non-empty source round-robin per cycle.
// Latency: push at edge t on an idle, uncontended source is broadcast on cdb_* after edge t+1.
// Backpressure: src_ready drops when a source FIFO is full or clear is high; rdy_in=0 freezes everything.
// Ports: clk_in, rst_in (async active-low), rdy_in stall, clear flush; src_valid/robid/val/ready per source;
//        cdb_valid/robid/val/src registered broadcast toward the ROB and reservation stations.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter  int N_SRC    = CDB_N_SRC_DEF,
    parameter  int DEPTH    = CDB_DEPTH_DEF,
    parameter  int ROB_ADDR = CDB_ROB_ADDR_DEF,
    parameter  int DATA_W   = CDB_DATA_W_DEF,
    localparam int SRC_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      clear,
    input  logic [N_SRC-1:0]          src_valid,
    input  logic [N_SRC*ROB_ADDR-1:0] src_robid,
    input  logic [N_SRC*DATA_W-1:0]   src_val,
    output logic [N_SRC-1:0]          src_ready,
    output logic                      cdb_valid,
    output logic [ROB_ADDR-1:0]       cdb_robid,
    output logic [DATA_W-1:0]         cdb_val,
    output logic [SRC_W-1:0]          cdb_src
);

    localparam int ENT_W = ROB_ADDR + DATA_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0] count [N_SRC];
    logic [ENT_W-1:0] head  [N_SRC];
    logic [N_SRC-1:0] push;
    logic [N_SRC-1:0] pop;
    logic             flush;
    logic [SRC_W-1:0] rr;
    logic             gnt_vld;
    logic [SRC_W-1:0] gnt_idx;

    // A flush only takes effect when the pipeline is advancing.
    assign flush = rdy_in & clear;

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        // Ready looks at the registered count only, so a full FIFO refuses
        // a push even in the cycle it is being popped.
        assign src_ready[g] = (count[g] != CNT_W'(DEPTH)) && !clear;
        assign push[g]      = rdy_in && !clear && src_valid[g] && src_ready[g];
        assign pop[g]       = rdy_in && !clear && gnt_vld && (gnt_idx == SRC_W'(g));

        cdb_src_fifo #(
            .DEPTH (DEPTH),
            .W     (ENT_W)
        ) u_fifo (
            .clk_in   (clk_in),
            .rst_in   (rst_in),
            .flush    (flush),
            .push     (push[g]),
            .pop      (pop[g]),
            .wr_dat   ({src_robid[g*ROB_ADDR +: ROB_ADDR], src_val[g*DATA_W +: DATA_W]}),
            .head_dat (head[g]),
            .count    (count[g])
        );
    end

    // Search starts just after the last winner; same-cycle pushes are not
    // yet counted, so a fresh result always waits at least one edge.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            if (!gnt_vld && (count[rr_next(int'(rr), k, N_SRC)] != '0)) begin
                gnt_vld = 1'b1;
                gnt_idx = SRC_W'(rr_next(int'(rr), k, N_SRC));
            end
        end
    end

    // Broadcast register; payload and source hold when nothing is granted.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rr        <= SRC_W'(N_SRC - 1);
            cdb_valid <= 1'b0;
            cdb_robid <= '0;
            cdb_val   <= '0;
            cdb_src   <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                cdb_valid <= 1'b0;
                rr        <= SRC_W'(N_SRC - 1);
            end else if (gnt_vld) begin
                cdb_valid            <= 1'b1;
                {cdb_robid, cdb_val} <= head[gnt_idx];
                cdb_src              <= gnt_idx;
                rr                   <= gnt_idx;
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

endmodule
